// File: rtl/ppu_pkg.sv
// ppu_pkg: PPU mode encoding, pixel-sink FSM states and LCD geometry
package ppu_pkg;
  typedef enum logic [1:0] {H_BLANK = 2'd0, V_BLANK = 2'd1, SCAN = 2'd2, DRAW = 2'd3} ppu_mode_t;
  typedef enum logic [2:0] {WAIT_FRAME, VBLANK, LINE_GAP, ACTIVE, FLUSH} sink_state_t;
  localparam int LCD_W = 160;
  localparam int LCD_H = 144;
  localparam int FB_W = 22;
endpackage

// File: rtl/lcd_wr_fifo.sv
// lcd_wr_fifo: synchronous show-ahead FIFO for framebuffer write entries
module lcd_wr_fifo #(
  parameter int W = 22,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/lcd_pixel_sink.sv
// lcd_pixel_sink: PPU pixel stream to packed, double-buffered framebuffer writes
module lcd_pixel_sink
  import ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int APPLY_PALETTE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PX_OUT,
  input  logic        PX_valid,
  input  logic [1:0]  PPU_MODE,
  input  logic [7:0]  BGP,
  output logic        fb_wr,
  input  logic        fb_ready,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        disp_bank,
  output logic        frame_done,
  input  logic        err_clr,
  output logic        err_ovf,
  output logic        err_len
);
  ppu_mode_t mode, mode_q;
  sink_state_t st, nxt;
  logic [7:0] x, y, sr, pbyte;
  logic [1:0] shade;
  logic [12:0] baddr;
  logic wr_bank, ent_vb, ent_sd, ent_draw, end_draw, frame_end, flush, px_in, acc, push_req, pv;
  logic full, empty, pop, ovf_set, len_set;
  logic [FB_W-1:0] pd, head;
  assign mode = ppu_mode_t'(PPU_MODE);
  assign ent_vb = mode == V_BLANK && mode_q != V_BLANK;
  assign ent_draw = mode == DRAW && mode_q != DRAW;
  assign ent_sd = ent_draw || (mode == SCAN && mode_q != SCAN);
  assign end_draw = mode == H_BLANK && mode_q == DRAW;
  assign frame_end = ent_vb && y != 8'd0;
  assign flush = st == FLUSH;
  assign px_in = PX_valid && st == ACTIVE;
  assign acc = px_in && x < 8'(LCD_W) && y < 8'(LCD_H);
  assign shade = APPLY_PALETTE != 0 ? BGP[{PX_OUT, 1'b1} -: 2] : PX_OUT;
  assign baddr = 13'(y) * 13'(LCD_W / 4) + 13'(x[7:2]);
  assign pbyte = flush ? sr << (4'd8 - {1'b0, x[1:0], 1'b0}) : {sr[5:0], shade};
  assign push_req = (acc && x[1:0] == 2'd3) || (flush && x[1:0] != 2'd0);
  assign pop = fb_wr && fb_ready;
  assign ovf_set = pv && full && !pop;
  assign len_set = (px_in && !acc) || (flush && x != 8'(LCD_W));
  assign fb_wr = rst && !empty;
  assign {fb_addr, fb_data} = fb_wr ? head : '0;
  always_comb
    nxt = ent_vb ? VBLANK :
          (st == VBLANK && ent_sd) ? LINE_GAP :
          (st == LINE_GAP && ent_draw) ? ACTIVE :
          (st == ACTIVE && end_draw) ? FLUSH :
          flush ? LINE_GAP : st;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= WAIT_FRAME;
      mode_q <= H_BLANK;
      x <= '0;
      y <= '0;
      sr <= '0;
      wr_bank <= 1'b1;
      disp_bank <= 1'b0;
      frame_done <= 1'b0;
      pv <= 1'b0;
      pd <= '0;
      err_ovf <= 1'b0;
      err_len <= 1'b0;
    end else begin
      st <= nxt;
      mode_q <= mode;
      frame_done <= frame_end;
      if (frame_end) begin
        disp_bank <= wr_bank;
        wr_bank <= ~wr_bank;
      end
      if (st == VBLANK && ent_sd) y <= '0;
      if (flush) y <= y + 8'd1;
      if (st == LINE_GAP && ent_draw) x <= '0;
      if (acc) begin
        sr <= {sr[5:0], shade};
        x <= x + 8'd1;
      end
      pv <= push_req;
      pd <= {wr_bank, baddr, pbyte};
      err_ovf <= err_clr ? 1'b0 : err_ovf | ovf_set;
      err_len <= err_clr ? 1'b0 : err_len | len_set;
    end
  end
  lcd_wr_fifo #(.W(FB_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(pv && !ovf_set),
    .din(pd),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_lcd_pixel_sink.sv
// tb_lcd_pixel_sink: scoreboard bench for the LCD pixel sink
module tb_lcd_pixel_sink;
  import ppu_pkg::*;
  typedef struct {
    logic [13:0] addr;
    logic [7:0] pal;
    logic [7:0] raw;
  } exp_t;
  logic clk = 0, rst = 0, PX_valid = 0, fb_ready = 1, err_clr = 0;
  logic [1:0] PX_OUT = 0, PPU_MODE = 0;
  logic [7:0] BGP = 8'hE4;
  logic fb_wr, disp_bank, frame_done, err_ovf, err_len;
  logic [13:0] fb_addr;
  logic [7:0] fb_data;
  logic r_wr, r_disp, r_fd, r_ovf, r_len;
  logic [13:0] r_addr;
  logic [7:0] r_data;
  exp_t sb[$];
  int checks = 0, errors = 0, wr_cnt = 0, pat = 0, y_m = 0;
  bit bank_m = 1, rr_en = 0, hold_v = 0;
  logic [21:0] hold_d;
  always #5 clk = ~clk;
  lcd_pixel_sink u_dut (
    .clk(clk), .rst(rst), .PX_OUT(PX_OUT), .PX_valid(PX_valid), .PPU_MODE(PPU_MODE), .BGP(BGP),
    .fb_wr(fb_wr), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .disp_bank(disp_bank), .frame_done(frame_done), .err_clr(err_clr), .err_ovf(err_ovf), .err_len(err_len)
  );
  lcd_pixel_sink #(.APPLY_PALETTE(0)) u_raw (
    .clk(clk), .rst(rst), .PX_OUT(PX_OUT), .PX_valid(PX_valid), .PPU_MODE(PPU_MODE), .BGP(BGP),
    .fb_wr(r_wr), .fb_ready(fb_ready), .fb_addr(r_addr), .fb_data(r_data),
    .disp_bank(r_disp), .frame_done(r_fd), .err_clr(err_clr), .err_ovf(r_ovf), .err_len(r_len)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    if (rr_en) fb_ready = 1'($urandom_range(1));
  endtask
  function automatic logic [1:0] pix(input int i);
    return pat == 0 ? 2'(i % 4) : pat == 1 ? ((i % 4) < 2 ? 2'd3 : 2'd0) :
           pat == 2 ? 2'd3 : 2'($urandom_range(3));
  endfunction
  task automatic put(input int g, input logic [7:0] d, input logic [7:0] r, inout int np, input int cap);
    exp_t e;
    if (np < cap) begin
      e.addr = {bank_m, 13'(y_m * 40 + g)};
      e.pal = d;
      e.raw = r;
      sb.push_back(e);
      np++;
    end
  endtask
  task automatic line(input int n, input int cap);
    logic [7:0] sp = 0, sr = 0, ps, pr;
    int k = 0, np = 0;
    PPU_MODE = SCAN;
    tick;
    tick;
    PPU_MODE = DRAW;
    tick;
    for (int i = 0; i < n; i++) begin
      logic [1:0] p;
      p = pix(i);
      if ($urandom_range(3) == 0) begin
        PX_valid = 0;
        tick;
      end
      PX_valid = 1;
      PX_OUT = p;
      if (i < 160 && y_m < 144) begin
        sp = {sp[5:0], 2'(BGP >> (2 * p))};
        sr = {sr[5:0], p};
        k = i + 1;
        if (k % 4 == 0) put(i / 4, sp, sr, np, cap);
      end
      tick;
    end
    PX_valid = 0;
    PPU_MODE = H_BLANK;
    if (k % 4 != 0) begin
      ps = sp << (8 - 2 * (k % 4));
      pr = sr << (8 - 2 * (k % 4));
      put(k / 4, ps, pr, np, cap);
    end
    tick;
    tick;
    tick;
    y_m++;
  endtask
  task automatic drain;
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      tick;
      t++;
    end
    chk("drain", sb.size(), 0);
    tick;
    tick;
  endtask
  task automatic clr;
    err_clr = 1;
    tick;
    err_clr = 0;
  endtask
  always @(negedge clk) if (rst) begin
    if (fb_wr && fb_ready) begin
      wr_cnt++;
      if (sb.size() == 0) chk("extra_wr", sb.size(), 1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("addr", fb_addr, e.addr);
        chk("data", fb_data, e.pal);
        chk("raw_wr", r_wr, 1);
        chk("raw_addr", r_addr, e.addr);
        chk("raw_data", r_data, e.raw);
      end
    end
    if (hold_v && fb_wr) chk("hold", {fb_addr, fb_data}, hold_d);
    hold_v = fb_wr && !fb_ready;
    hold_d = {fb_addr, fb_data};
  end
  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tick;
    tick;
    chk("rst_wr", fb_wr, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_disp", disp_bank, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_len", err_len, 0);
    rst = 1;
    PPU_MODE = DRAW;
    tick;
    for (int i = 0; i < 12; i++) begin
      PX_valid = 1;
      PX_OUT = 2'(i);
      tick;
    end
    PX_valid = 0;
    PPU_MODE = H_BLANK;
    repeat (4) tick;
    chk("pre_frame_wr", wr_cnt, 0);
    PPU_MODE = V_BLANK;
    tick;
    tick;
    chk("vb_no_fd", frame_done, 0);
    wr_cnt = 0;
    pat = 0;
    line(160, 1000);
    drain;
    chk("full_cnt", wr_cnt, 40);
    chk("full_len", err_len, 0);
    BGP = 8'h1B;
    pat = 1;
    line(160, 1000);
    drain;
    BGP = 8'hE4;
    pat = 2;
    wr_cnt = 0;
    line(6, 1000);
    drain;
    chk("short_cnt", wr_cnt, 2);
    chk("short_len", err_len, 1);
    clr;
    chk("clr_len", err_len, 0);
    pat = 3;
    line(160, 1000);
    drain;
    chk("line3_len", err_len, 0);
    err_clr = 1;
    line(170, 1000);
    err_clr = 0;
    drain;
    chk("clr_prio", err_len, 0);
    line(170, 1000);
    drain;
    chk("long_len", err_len, 1);
    clr;
    fb_ready = 0;
    line(160, 8);
    repeat (4) tick;
    chk("bp_ovf", err_ovf, 1);
    chk("bp_wr_held", fb_wr, 1);
    wr_cnt = 0;
    fb_ready = 1;
    drain;
    chk("bp_cnt", wr_cnt, 8);
    clr;
    chk("clr_ovf", err_ovf, 0);
    rr_en = 1;
    while (y_m < 144) line(160, 1000);
    line(8, 1000);
    drain;
    chk("beyond_h_len", err_len, 1);
    clr;
    chk("disp_before", disp_bank, 0);
    PPU_MODE = V_BLANK;
    tick;
    chk("frame_done", frame_done, 1);
    chk("disp_bank", disp_bank, 1);
    tick;
    chk("frame_done_1cyc", frame_done, 0);
    bank_m = 0;
    y_m = 0;
    pat = 0;
    line(160, 1000);
    drain;
    chk("ovf_final", err_ovf, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
